// File: rtl/test_sequencer_pkg.sv
// Shared types and helpers for the test sequencer slice.
package test_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_RELEASE,
    ST_GAP,
    ST_FINISH
  } seq_state_t;

  localparam int unsigned TOGGLE_CNT_W = 8;

  // Slot index width; a single slot still gets a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/test_sequencer_if.sv
// Activate/done/test-out bundle between the sequencer and its responders.
interface test_sequencer_if #(
  parameter int unsigned N_TESTS = 4
) ();

  logic [N_TESTS-1:0] activate;
  logic [N_TESTS-1:0] done;
  logic [N_TESTS-1:0] to;

  modport master (output activate, input done, input to);
  modport slave  (input activate, output done, output to);

endinterface

// File: rtl/test_sequencer_edge_counter.sv
// Saturating transition counter on a single synchronous line.
// `count` already includes a transition present in the current cycle,
// so a verdict taken on this cycle sees it.
module edge_counter
  import test_seq_pkg::*;
(
  input  logic                    clk_50mhz,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    sig,
  output logic [TOGGLE_CNT_W-1:0] count
);

  logic [TOGGLE_CNT_W-1:0] cnt_q;
  logic                    prev_sig;

  // Registered count plus this cycle's transition, held at all-ones.
  always_comb begin
    count = cnt_q;
    if ((sig != prev_sig) && (cnt_q != '1)) begin
      count = cnt_q + TOGGLE_CNT_W'(1);
    end
  end

  // Clear re-baselines on the current line level; enable tracks it.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      cnt_q    <= '0;
      prev_sig <= 1'b0;
    end else if (clr) begin
      cnt_q    <= '0;
      prev_sig <= sig;
    end else if (en) begin
      cnt_q    <= count;
      prev_sig <= sig;
    end
  end

endmodule

// File: rtl/test_sequencer.sv
// Walks a bank of test responders one slot at a time: arms a slot,
// waits for done or timeout, scores its test-out transitions, then
// releases it and idles for a gap before the next slot.
module test_sequencer
  import test_seq_pkg::*;
#(
  parameter int unsigned N_TESTS        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 600_000_000,
  parameter int unsigned EXPECT_TOGGLES = 10,
  parameter int unsigned GAP_CYCLES     = 16
) (
  input  logic                              clk_50mhz,
  input  logic                              reset,
  input  logic                              start,
  test_sequencer_if.master                  tif,
  output logic                              busy,
  output logic [idx_width(N_TESTS)-1:0]     cur_idx,
  output logic [N_TESTS-1:0]                pass,
  output logic [N_TESTS-1:0]                fail,
  output logic                              all_done
);

  localparam int unsigned IDX_W   = idx_width(N_TESTS);
  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);

  seq_state_t              state;
  logic [TIMER_W-1:0]      timer;
  logic [GAP_W-1:0]        gap_cnt;
  logic                    to_sel;
  logic                    done_sel;
  logic                    ec_clr;
  logic                    ec_en;
  logic [TOGGLE_CNT_W-1:0] tog_cnt;

  // Only the selected slot's lines are ever observed.
  always_comb begin
    to_sel   = tif.to[cur_idx];
    done_sel = tif.done[cur_idx];
    ec_clr   = (state == ST_ARM);
    ec_en    = (state == ST_RUN);
  end

  edge_counter u_edge_counter (
    .clk_50mhz (clk_50mhz),
    .reset     (reset),
    .clr       (ec_clr),
    .en        (ec_en),
    .sig       (to_sel),
    .count     (tog_cnt)
  );

  // Sequencer FSM with registered outputs, timer and gap counter.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      state        <= ST_IDLE;
      tif.activate <= '0;
      busy         <= 1'b0;
      cur_idx      <= '0;
      pass         <= '0;
      fail         <= '0;
      all_done     <= 1'b0;
      timer        <= '0;
      gap_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pass     <= '0;
            fail     <= '0;
            all_done <= 1'b0;
            cur_idx  <= '0;
            state    <= ST_ARM;
          end
        end
        ST_ARM: begin
          tif.activate <= N_TESTS'(1) << cur_idx;
          busy         <= 1'b1;
          timer        <= '0;
          state        <= ST_RUN;
        end
        ST_RUN: begin
          timer <= timer + TIMER_W'(1);
          if (done_sel) begin
            if (tog_cnt == TOGGLE_CNT_W'(EXPECT_TOGGLES)) begin
              pass[cur_idx] <= 1'b1;
            end else begin
              fail[cur_idx] <= 1'b1;
            end
            state <= ST_RELEASE;
          end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
            fail[cur_idx] <= 1'b1;
            state         <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          tif.activate <= '0;
          gap_cnt      <= GAP_W'(GAP_CYCLES - 1);
          state        <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            if (cur_idx == IDX_W'(N_TESTS - 1)) begin
              state <= ST_FINISH;
            end else begin
              cur_idx <= cur_idx + IDX_W'(1);
              state   <= ST_ARM;
            end
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        ST_FINISH: begin
          all_done <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: responder models driven from per-slot
// schedules, a timeline model of the expected outputs, directed
// scenarios and randomized runs.
module tb_test_sequencer;

  localparam int N = 2;
  localparam int T = 100;
  localparam int E = 3;
  localparam int G = 4;

  logic         clk_50mhz = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         busy;
  logic         all_done;
  logic [0:0]   cur_idx;
  logic [N-1:0] pass;
  logic [N-1:0] fail;

  test_sequencer_if #(.N_TESTS(N)) tif ();

  test_sequencer #(
    .N_TESTS        (N),
    .TIMEOUT_CYCLES (T),
    .EXPECT_TOGGLES (E),
    .GAP_CYCLES     (G)
  ) dut (
    .clk_50mhz (clk_50mhz),
    .reset     (reset),
    .start     (start),
    .tif       (tif),
    .busy      (busy),
    .cur_idx   (cur_idx),
    .pass      (pass),
    .fail      (fail),
    .all_done  (all_done)
  );

  always #5 clk_50mhz = ~clk_50mhz;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Responder schedule: bit o of sched flips `to` right after the o-th
  // edge following activate; done is first seen done_at edges after it.
  bit [127:0] sched [N];
  int         done_at [N];
  bit         noise = 1'b0;
  bit         idle_done = 1'b0;
  int         ofs [N];
  bit         was_act [N];

  // Timeline model
  bit           run_valid = 1'b0;
  int           A [N];
  int           V [N];
  int           F;
  logic [N-1:0] vpass;
  logic [N-1:0] e_act, e_pass, e_fail;
  logic         e_busy, e_all;
  logic [0:0]   e_idx;
  bit           rst_pend = 1'b1;
  bit           start_pend = 1'b0;
  bit           chk_en = 1'b0;
  int           ce;

  function automatic void check(input string nm, input logic [31:0] got,
                                input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endfunction

  // Expected timeline of one run accepted at edge e.
  function automatic void build(input int e);
    int t, d, cnt;
    t = e + 1;
    for (int s = 0; s < N; s++) begin
      A[s] = t;
      d = (done_at[s] != 0 && done_at[s] <= T) ? done_at[s] : T;
      V[s] = t + d;
      cnt = 0;
      for (int o = 0; o < d; o++) if (sched[s][o]) cnt++;
      vpass[s] = (done_at[s] != 0 && done_at[s] <= T && cnt == E);
      t = V[s] + 2 + G;
    end
    F = t;
    run_valid = 1'b1;
  endfunction

  always @(posedge clk_50mhz) cyc = cyc + 1;

  // Responder models
  always @(posedge clk_50mhz) begin
    #1;
    for (int s = 0; s < N; s++) begin
      if (tif.activate[s] === 1'b1) begin
        if (!was_act[s]) ofs[s] = 0;
        if (ofs[s] < 128 && sched[s][ofs[s]]) tif.to[s] = ~tif.to[s];
        tif.done[s] = (done_at[s] != 0 && ofs[s] >= done_at[s] - 1);
        ofs[s]++;
        was_act[s] = 1'b1;
      end else begin
        was_act[s] = 1'b0;
        tif.done[s] = idle_done || (noise && $urandom_range(0, 1) == 1);
        if (noise) tif.to[s] = ($urandom_range(0, 1) == 1);
      end
    end
  end

  // Per-cycle compare against the timeline model
  always @(negedge clk_50mhz) begin
    ce = cyc;
    if (rst_pend) begin
      run_valid = 1'b0;
      e_act = '0; e_pass = '0; e_fail = '0;
      e_busy = 1'b0; e_all = 1'b0; e_idx = '0;
      chk_en = 1'b1;
    end else if (start_pend && (!run_valid || ce - 1 >= F)) begin
      build(ce);
    end
    if (run_valid) begin
      e_act = '0; e_pass = '0; e_fail = '0; e_idx = '0;
      for (int s = 0; s < N; s++) begin
        if (ce >= A[s] && ce <= V[s]) e_act[s] = 1'b1;
        if (s > 0 && ce >= A[s] - 1) e_idx = 1'(s);
        if (ce >= V[s]) begin
          if (vpass[s]) e_pass[s] = 1'b1;
          else          e_fail[s] = 1'b1;
        end
      end
      e_busy = (ce >= A[0] && ce < F);
      e_all  = (ce >= F);
    end
    if (chk_en) begin
      check("activate", 32'(tif.activate), 32'(e_act));
      check("busy",     32'(busy),         32'(e_busy));
      check("all_done", 32'(all_done),     32'(e_all));
      check("pass",     32'(pass),         32'(e_pass));
      check("fail",     32'(fail),         32'(e_fail));
      check("cur_idx",  32'(cur_idx),      32'(e_idx));
    end
    rst_pend   = (reset === 1'b1);
    start_pend = (start === 1'b1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_50mhz);
      #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_all(input string nm);
    int n = 0;
    while (all_done !== 1'b1 && n < 3000) begin
      step();
      n++;
    end
    check(nm, 32'(all_done), 32'd1);
  endtask

  task automatic wait_act(input logic [N-1:0] v, input string nm);
    int n = 0;
    while (tif.activate !== v && n < 3000) begin
      step();
      n++;
    end
    check(nm, 32'(tif.activate), 32'(v));
  endtask

  task automatic set_slot(input int s, input int o0, input int o1,
                          input int o2, input int d);
    sched[s] = '0;
    if (o0 >= 0) sched[s][o0] = 1'b1;
    if (o1 >= 0) sched[s][o1] = 1'b1;
    if (o2 >= 0) sched[s][o2] = 1'b1;
    done_at[s] = d;
  endtask

  task automatic rand_slot(input int s);
    int placed, o, r;
    sched[s] = '0;
    if ($urandom_range(0, 1) == 1) begin
      done_at[s] = $urandom_range(E + 1, T);
      placed = 0;
      while (placed < E) begin
        o = $urandom_range(0, done_at[s] - 1);
        if (!sched[s][o]) begin
          sched[s][o] = 1'b1;
          placed++;
        end
      end
      if ($urandom_range(0, 1) == 1) sched[s][$urandom_range(done_at[s], 120)] = 1'b1;
    end else begin
      repeat ($urandom_range(0, 6)) sched[s][$urandom_range(0, 110)] = 1'b1;
      r = $urandom_range(0, 4);
      done_at[s] = (r == 0) ? 0 : $urandom_range(1, T + 10);
    end
  endtask

  initial begin
    int n;
    tif.done = '0;
    tif.to   = '0;
    for (int s = 0; s < N; s++) begin
      sched[s] = '0; done_at[s] = 0; ofs[s] = 0; was_act[s] = 1'b0;
    end

    step(3);
    reset = 1'b0;
    check("rst_activate", 32'(tif.activate), 32'd0);
    check("rst_busy",     32'(busy),         32'd0);
    check("rst_pass",     32'(pass),         32'd0);
    check("rst_all_done", 32'(all_done),     32'd0);
    step(2);

    // Both slots pass
    set_slot(0, 2, 5, 8, 20);
    set_slot(1, 1, 4, 9, 20);
    do_start();
    check("lat_arm_act", 32'(tif.activate), 32'd0);
    step();
    check("lat_act0", 32'(tif.activate), 32'b01);
    check("lat_busy", 32'(busy), 32'd1);
    wait_all("s1_all_done");
    check("s1_pass", 32'(pass), 32'b11);
    check("s1_fail", 32'(fail), 32'b00);
    check("s1_busy", 32'(busy), 32'd0);
    step(3);

    // Toggle-count mismatch on slot 0
    set_slot(0, 3, 6, -1, 20);
    set_slot(1, 2, 5, 8, 20);
    do_start();
    wait_all("s2_all_done");
    check("s2_pass", 32'(pass), 32'b10);
    check("s2_fail", 32'(fail), 32'b01);
    step(2);

    // Slot 1 never raises done
    set_slot(0, 2, 5, 8, 20);
    set_slot(1, 2, 5, 8, 0);
    do_start();
    wait_act(2'b10, "s3_act1");
    n = 0;
    while (fail[1] !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    check("s3_timeout_lat", 32'(n), 32'd100);
    check("s3_act_held", 32'(tif.activate), 32'b10);
    step();
    check("s3_act_drop", 32'(tif.activate), 32'd0);
    wait_all("s3_all_done");
    check("s3_pass", 32'(pass), 32'b01);
    step(2);

    // done on the timeout cycle with the last toggle in that cycle
    set_slot(0, 10, 50, 99, 100);
    set_slot(1, 2, 5, 8, 20);
    do_start();
    wait_all("s4_all_done");
    check("s4_pass", 32'(pass), 32'b11);
    step(2);

    // Ignored start and foreign done
    idle_done = 1'b1;
    set_slot(0, 2, 5, 8, 20);
    set_slot(1, 2, 5, 8, 20);
    do_start();
    wait_act(2'b01, "s5_act0");
    check("s5_idx0", 32'(cur_idx), 32'd0);
    step(3);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("s5_no_restart", 32'(tif.activate), 32'b01);
    wait_act(2'b10, "s5_act1");
    check("s5_idx1", 32'(cur_idx), 32'd1);
    wait_all("s5_all_done");
    check("s5_pass", 32'(pass), 32'b11);
    idle_done = 1'b0;
    step(2);

    // Reset during slot 1, then a fresh run
    set_slot(0, 2, 5, 8, 20);
    set_slot(1, 2, 5, 8, 20);
    do_start();
    wait_act(2'b10, "s6_act1");
    step(5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("s6_act",      32'(tif.activate), 32'd0);
    check("s6_busy",     32'(busy),         32'd0);
    check("s6_pass",     32'(pass),         32'd0);
    check("s6_fail",     32'(fail),         32'd0);
    check("s6_all_done", 32'(all_done),     32'd0);
    check("s6_idx",      32'(cur_idx),      32'd0);
    step(2);
    do_start();
    step();
    check("s6_rerun_act0", 32'(tif.activate), 32'b01);
    wait_all("s6_all_done2");
    check("s6_rerun_pass", 32'(pass), 32'b11);
    step(2);

    // Randomized runs with noise on unselected lines
    noise = 1'b1;
    repeat (20) begin
      for (int s = 0; s < N; s++) rand_slot(s);
      idle_done = ($urandom_range(0, 3) == 0);
      do_start();
      wait_all("rand_all_done");
      step($urandom_range(1, 4));
    end
    noise = 1'b0;
    idle_done = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
